// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Main control FSM of the multicycle MIPS-subset processor. Steps
//            the shared memory, ALU and register file through 3-5 cycles per
//            instruction and drives every datapath enable and mux select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q;
  state_t     state_d;
  state_t     out_state;   // state used for output decode; FETCH while in reset
  logic       op_ok;
  logic       pcwrite;
  logic       branch_eq;
  logic       branch_ne;
  logic [1:0] aluop;

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Opcode support check; BNE only counts when it is built in
  always_comb begin
    op_ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
      OP_BNE:                                        op_ok = SUPPORT_BNE;
      default:                                       op_ok = 1'b0;
    endcase
  end

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_BNE:       state_d = SUPPORT_BNE ? BNEEX : FETCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW) begin
          state_d = MEMRD;
        end else if (op == OP_SW) begin
          state_d = MEMWR;
        end else begin
          state_d = FETCH;
        end
      end
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Moore output decode; reset shows FETCH values with all enables suppressed
  always_comb begin
    out_state = reset ? FETCH : state_q;
    iord      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    pcwrite   = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    aluop     = 2'b00;
    illegal   = 1'b0;
    case (out_state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = ~op_ok;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch_eq = 1'b1;
      end
      BNEEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch_ne = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // out_state is already FETCH under reset, so only the FETCH enables need masking
    if (reset) begin
      irwrite = 1'b0;
      pcwrite = 1'b0;
    end
    pcen = pcwrite | (branch_eq & zero) | (branch_ne & ~zero);
  end

  // ALU decoder: aluop selects add/sub, or funct decides for R-type
  always_comb begin
    alucontrol = 3'b010;
    if (aluop == 2'b01) begin
      alucontrol = 3'b110;
    end else if (aluop == 2'b10) begin
      case (funct)
        6'b100000: alucontrol = 3'b010;
        6'b100010: alucontrol = 3'b110;
        6'b100100: alucontrol = 3'b000;
        6'b100101: alucontrol = 3'b001;
        6'b101010: alucontrol = 3'b111;
        default:   alucontrol = 3'b010;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Scoreboard bench for multicycle_controller. One DUT supports BNE,
//            a second is built without it and is fed op=000101 continuously.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  typedef struct {
    logic [19:0] v;
    string       tag;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [5:0] op;
  logic [5:0] op2;
  logic [5:0] funct;
  logic       zero;

  logic       a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite;
  logic       a_alusrca, a_pcen, a_illegal;
  logic [1:0] a_alusrcb, a_pcsrc;
  logic [2:0] a_alucontrol;
  logic [3:0] a_state;

  logic       b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite;
  logic       b_alusrca, b_pcen, b_illegal;
  logic [1:0] b_alusrcb, b_pcsrc;
  logic [2:0] b_alucontrol;
  logic [3:0] b_state;

  exp_t       q1[$];
  exp_t       q2[$];
  exp_t       e1;
  exp_t       e2;
  int         errors;
  int         checks;
  logic [3:0] p2;     // expected state of the no-BNE DUT (alternates FETCH/DECODE)

  logic [19:0] v1;
  logic [19:0] v2;
  assign v1 = {a_state, a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite,
               a_alusrca, a_alusrcb, a_pcsrc, a_pcen, a_alucontrol, a_illegal};
  assign v2 = {b_state, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite,
               b_alusrca, b_alusrcb, b_pcsrc, b_pcen, b_alucontrol, b_illegal};

  multicycle_controller #(.SUPPORT_BNE(1'b1)) dut (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(a_iord), .memwrite(a_memwrite), .irwrite(a_irwrite), .regdst(a_regdst),
    .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrca(a_alusrca),
    .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .pcen(a_pcen), .alucontrol(a_alucontrol),
    .state(a_state), .illegal(a_illegal)
  );

  multicycle_controller #(.SUPPORT_BNE(1'b0)) dut_nobne (
    .clock(clock), .reset(reset), .op(op2), .funct(funct), .zero(zero),
    .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite), .regdst(b_regdst),
    .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca),
    .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .pcen(b_pcen), .alucontrol(b_alucontrol),
    .state(b_state), .illegal(b_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected output vector for a given state and inputs, from the output table
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic rst,
                                          input logic [5:0] o, input logic [5:0] fn,
                                          input logic z, input logic bne_ok);
    logic       iord, mw, irw, rd, m2r, rw, asa, pcw, pen, ill, ok;
    logic [1:0] asb, psrc, aop;
    logic [2:0] ac;
    logic [3:0] eff;
    eff = rst ? 4'd0 : st;
    iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; asa = 0; pcw = 0; ill = 0;
    asb = 2'b00; psrc = 2'b00; aop = 2'b00;
    ok = (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000100) ||
         (o == 6'b001000) || (o == 6'b000010) || ((o == 6'b000101) && bne_ok);
    case (eff)
      4'd0:  begin asb = 2'b01; irw = 1; pcw = 1; end
      4'd1:  begin asb = 2'b11; ill = !ok; end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  iord = 1;
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin iord = 1; mw = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8, 4'd12: begin asa = 1; aop = 2'b01; psrc = 2'b01; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin psrc = 2'b10; pcw = 1; end
      default: ;
    endcase
    pen = pcw | ((eff == 4'd8) & z) | ((eff == 4'd12) & !z);
    if (rst) begin
      irw = 0; pen = 0;
    end
    if (aop == 2'b01) ac = 3'b110;
    else if (aop == 2'b10) begin
      case (fn)
        6'b100010: ac = 3'b110;
        6'b100100: ac = 3'b000;
        6'b100101: ac = 3'b001;
        6'b101010: ac = 3'b111;
        default:   ac = 3'b010;
      endcase
    end else ac = 3'b010;
    return {st, iord, mw, irw, rd, m2r, rw, asa, asb, psrc, pen, ac, ill};
  endfunction

  // Push expectations for the current cycle of both DUTs, then advance one clock
  task automatic tick(input logic [3:0] st, input string tag);
    exp_t x;
    x.v = exp_vec(st, reset, op, funct, zero, 1'b1);
    x.tag = tag;
    q1.push_back(x);
    x.v = exp_vec(p2, reset, op2, funct, zero, 1'b0);
    x.tag = {tag, "/nobne"};
    q2.push_back(x);
    p2 = reset ? 4'd0 : ((p2 == 4'd0) ? 4'd1 : 4'd0);
    @(posedge clock);
    #1;
  endtask

  // One instruction: hand-written state sequence packed MSB-first, n entries
  task automatic run(input string tag, input logic [5:0] o, input logic [5:0] fn,
                     input logic z, input int n, input logic [19:0] seq);
    op = o; funct = fn; zero = z;
    for (int i = 0; i < n; i++) tick(seq[19-4*i -: 4], tag);
  endtask

  // Monitor: compares each DUT against the head of its scoreboard mid-cycle
  always @(negedge clock) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      checks++;
      if (v1 !== e1.v) begin
        errors++;
        $display("FAIL %s t=%0t got=%05h exp=%05h (state got %0d exp %0d)",
                 e1.tag, $time, v1, e1.v, v1[19:16], e1.v[19:16]);
      end
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      checks++;
      if (v2 !== e2.v) begin
        errors++;
        $display("FAIL %s t=%0t got=%05h exp=%05h (state got %0d exp %0d)",
                 e2.tag, $time, v2, e2.v, v2[19:16], e2.v[19:16]);
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    op     = 6'b000000;
    op2    = 6'b000101;
    funct  = 6'b000000;
    zero   = 1'b0;
    p2     = 4'd0;
    @(posedge clock);
    #1;
    // Reset held three cycles
    tick(4'd0, "reset");
    tick(4'd0, "reset");
    tick(4'd0, "reset");
    reset = 1'b0;

    run("lw",       6'b100011, 6'b000000, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4});
    run("rt_slt",   6'b000000, 6'b101010, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
    run("rt_sub",   6'b000000, 6'b100010, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
    run("rt_and",   6'b000000, 6'b100100, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
    run("rt_or",    6'b000000, 6'b100101, 1'b1, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
    run("rt_other", 6'b000000, 6'b111111, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
    run("beq_z1",   6'b000100, 6'b000000, 1'b1, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0});
    run("beq_z0",   6'b000100, 6'b000000, 1'b0, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0});
    run("bne_z1",   6'b000101, 6'b000000, 1'b1, 3, {4'd0, 4'd1, 4'd12, 4'd0, 4'd0});
    run("bne_z0",   6'b000101, 6'b000000, 1'b0, 3, {4'd0, 4'd1, 4'd12, 4'd0, 4'd0});
    run("addi",     6'b001000, 6'b100010, 1'b0, 4, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0});
    run("j",        6'b000010, 6'b000000, 1'b0, 3, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0});
    run("illegal",  6'b111111, 6'b000000, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0});
    run("sw",       6'b101011, 6'b000000, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0});

    // sw abandoned by reset during MEMADR
    run("sw_rst",   6'b101011, 6'b000000, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0});
    reset = 1'b1;
    tick(4'd2, "sw_rst_memadr");
    reset = 1'b0;
    run("post_rst", 6'b000010, 6'b000000, 1'b0, 3, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0});

    // Drain the scoreboards with a bounded wait
    for (int i = 0; i < 10 && (q1.size() > 0 || q2.size() > 0); i++) @(posedge clock);
    @(posedge clock);
    if (q1.size() > 0 || q2.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", q1.size() + q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
